// File: rtl/hog_window_arbiter_pkg.sv
// Shared HOG constants and types for the scale-stream arbiter.
// Scale count matches the image pyramid depth.
package hog_window_arbiter_pkg;

  localparam int HOG_PYR_SCALES = 15;
  localparam int HOG_NUM_SCALES = HOG_PYR_SCALES;
  localparam int HOG_WINDOW_W   = 32 * 36;
  localparam int HOG_SCALE_W    = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic int wrap_inc(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/hog_window_arbiter_rr_select.sv
// Stateless round-robin search: first request at or after ptr,
// wrapping from N-1 back to 0.
module rr_select #(
  parameter int N  = 15,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hog_window_arbiter.sv
// Round-robin funnel of per-scale HOG windows into one classifier
// port through a single-entry output register, with a frame counter.
module hog_window_arbiter
  import hog_window_arbiter_pkg::*;
#(
  parameter int NUM_SCALES   = HOG_NUM_SCALES,
  parameter int WINDOW_WIDTH = HOG_WINDOW_W,
  parameter int SCALE_W      = HOG_SCALE_W,
  parameter int COUNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SCALES-1:0]            win_valid,
  input  logic [NUM_SCALES*WINDOW_WIDTH-1:0] win_data,
  output logic [NUM_SCALES-1:0]            win_ready,
  output logic                             out_valid,
  output logic [WINDOW_WIDTH-1:0]          out_data,
  output logic [SCALE_W-1:0]               out_scale,
  input  logic                             out_ready,
  input  logic                             frame_start,
  output logic [COUNT_W-1:0]               windows_sent
);

  out_state_e               state_q, state_d;
  logic [WINDOW_WIDTH-1:0]  data_q, data_d;
  logic [SCALE_W-1:0]       scale_q, scale_d;
  logic [SCALE_W-1:0]       ptr_q, ptr_d;
  logic [COUNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_SCALES-1:0]    rr_gnt;
  logic [SCALE_W-1:0]       rr_idx;
  logic                     accept;
  logic                     grant;
  logic                     out_hs;

  rr_select #(
    .N  (NUM_SCALES),
    .IW (SCALE_W)
  ) u_rr (
    .req (win_valid),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  assign out_valid    = (state_q == ST_FULL);
  assign out_data     = data_q;
  assign out_scale    = scale_q;
  assign windows_sent = cnt_q;

  assign accept    = !out_valid || out_ready;
  // Reset blocks grants so nothing is accepted in a reset cycle.
  assign win_ready = (accept && !rst) ? rr_gnt : '0;
  assign grant     = |win_ready;
  assign out_hs    = out_valid && out_ready && !rst;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    scale_d = scale_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (grant) begin
      state_d = ST_FULL;
      data_d  = win_data[int'(rr_idx)*WINDOW_WIDTH +: WINDOW_WIDTH];
      scale_d = rr_idx;
      ptr_d   = SCALE_W'(wrap_inc(int'(rr_idx), NUM_SCALES));
    end else if (accept) begin
      state_d = ST_EMPTY;
    end
    if (frame_start) begin
      cnt_d = out_hs ? COUNT_W'(1) : '0;
    end else if (out_hs && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      scale_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      scale_q <= scale_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hog_window_arbiter.sv
// Directed checks of the HOG window arbiter: fairness, wrap,
// backpressure, frame counter, saturation, mid-transfer reset.
module tb_hog_window_arbiter;

  localparam int NS = 15;
  localparam int WW = 1152;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     win_valid;
  logic [NS*WW-1:0]  win_data;
  logic [NS-1:0]     win_ready;
  logic              out_valid;
  logic [WW-1:0]     out_data;
  logic [3:0]        out_scale;
  logic              out_ready;
  logic              frame_start;
  logic [15:0]       windows_sent;

  logic [3:0]        v2;
  logic [31:0]       d2;
  logic [3:0]        r2;
  logic              ov2;
  logic [7:0]        od2;
  logic [1:0]        os2;
  logic              ordy2;
  logic              fs2;
  logic [1:0]        ws2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hog_window_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .win_valid    (win_valid),
    .win_data     (win_data),
    .win_ready    (win_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_scale    (out_scale),
    .out_ready    (out_ready),
    .frame_start  (frame_start),
    .windows_sent (windows_sent)
  );

  hog_window_arbiter #(
    .NUM_SCALES   (4),
    .WINDOW_WIDTH (8),
    .SCALE_W      (2),
    .COUNT_W      (2)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .win_valid    (v2),
    .win_data     (d2),
    .win_ready    (r2),
    .out_valid    (ov2),
    .out_data     (od2),
    .out_scale    (os2),
    .out_ready    (ordy2),
    .frame_start  (fs2),
    .windows_sent (ws2)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'hA0 + 8'(i);
  endfunction

  function automatic logic [63:0] lo64(input int i);
    return {8{pat(i)}};
  endfunction

  function automatic logic [63:0] bit1(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int s);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".scale"}, 64'(out_scale), 64'(s));
    chk({tag, ".dlo"}, out_data[63:0], lo64(s));
    chk({tag, ".dhi"}, out_data[WW-1 -: 64], lo64(s));
  endtask

  initial begin
    for (int i = 0; i < NS; i++)
      win_data[i*WW +: WW] = {144{pat(i)}};
    d2          = 32'h44332211;
    rst         = 1'b1;
    win_valid   = '1;
    out_ready   = 1'b1;
    frame_start = 1'b0;
    v2          = '0;
    ordy2       = 1'b1;
    fs2         = 1'b0;

    // reset held two cycles with all scales requesting
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst.wr", 64'(win_ready), 64'd0);
      step();
      chk("rst.ov", 64'(out_valid), 64'd0);
      chk("rst.ws", 64'(windows_sent), 64'd0);
      chk("rst.sc", 64'(out_scale), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("fair.wr0", 64'(win_ready), bit1(0));

    // fairness: 0..14 then 0
    for (int k = 0; k < NS; k++) begin
      step();
      chk_out($sformatf("fair%0d", k), k);
      chk("fair.wr", 64'(win_ready), bit1((k + 1) % NS));
    end
    step();
    chk_out("fair.wrap", 0);
    chk("fair.ws", 64'(windows_sent), 64'd15);

    // wrap-around: grant 13, then 14, then 2; ptr ends at 3
    win_valid = NS'(bit1(13));
    step();
    chk_out("wrap.g13", 13);
    win_valid = NS'(bit1(14) | bit1(2));
    #1;
    chk("wrap.wr14", 64'(win_ready), bit1(14));
    step();
    chk_out("wrap.g14", 14);
    chk("wrap.wr2", 64'(win_ready), bit1(2));
    step();
    chk_out("wrap.g2", 2);
    win_valid = NS'(bit1(2) | bit1(3));
    #1;
    chk("wrap.ptr3", 64'(win_ready), bit1(3));
    step();
    chk_out("wrap.g3", 3);

    // backpressure on scale 5 with scale 9 pending
    win_valid = NS'(bit1(5) | bit1(9));
    #1;
    chk("bp.wr5", 64'(win_ready), bit1(5));
    step();
    chk_out("bp.g5", 5);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp.wr0", 64'(win_ready), 64'd0);
      step();
      chk_out($sformatf("bp.hold%0d", c), 5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.wr9", 64'(win_ready), bit1(9));
    step();
    chk_out("bp.g9", 9);
    win_valid = '0;
    #1;
    chk("idle.wr", 64'(win_ready), 64'd0);
    step();
    chk("idle.ov", 64'(out_valid), 64'd0);

    // frame counter: clear, 3 handshakes, coincident frame_start
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fr.clr", 64'(windows_sent), 64'd0);
    win_valid = NS'(bit1(0));
    step();
    chk("fr.ws0", 64'(windows_sent), 64'd0);
    step();
    step();
    step();
    chk("fr.ws3", 64'(windows_sent), 64'd3);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fr.coinc", 64'(windows_sent), 64'd1);
    step();
    chk("fr.ws2", 64'(windows_sent), 64'd2);

    // saturation on the COUNT_W=2 instance
    v2 = 4'b0001;
    step();
    chk("sat.ov", 64'(ov2), 64'd1);
    chk("sat.d", 64'(od2), 64'h11);
    for (int c = 0; c < 3; c++) step();
    chk("sat.ws3", 64'(ws2), 64'd3);
    step();
    step();
    chk("sat.hold", 64'(ws2), 64'd3);
    fs2 = 1'b1;
    v2  = '0;
    ordy2 = 1'b0;
    step();
    fs2 = 1'b0;
    chk("sat.clr", 64'(ws2), 64'd0);

    // mid-transfer reset: ptr returns to 0
    out_ready = 1'b0;
    win_valid = NS'(bit1(0) | bit1(3));
    step();
    chk("mrst.pre", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mrst.wr", 64'(win_ready), 64'd0);
    step();
    rst = 1'b0;
    chk("mrst.ov", 64'(out_valid), 64'd0);
    chk("mrst.ws", 64'(windows_sent), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("mrst.ptr0", 64'(win_ready), bit1(0));
    step();
    chk_out("mrst.g0", 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
